regfile_scoreboard: RTL and testbench

Parametrised successor to the single-write MIPS register file. It adds an asynchronous clear, a second write port for long-latency writeback, same-cycle write-to-read bypass and a per-register pending-write scoreboard. It sits between decode and writeback in the datapath. Decode reads operands and busy flags, the ALU writes through port 1, and load/multiply writeback writes through port 2 and retires the pending bit.

---
 rtl/regfile_scoreboard.sv | 97 +++++++++
 tb/tb_regfile_scoreboard.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Two-write-port register file with same-cycle bypass and a per-register
// pending-write scoreboard for long-latency writeback.
module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] readReg1,
    input  logic [ADDR_W-1:0] readReg2,
    output logic [DATA_W-1:0] readDat1,
    output logic [DATA_W-1:0] readDat2,
    output logic              busy1,
    output logic              busy2,
    input  logic              regWrite,
    input  logic [ADDR_W-1:0] writeReg,
    input  logic [DATA_W-1:0] writeData,
    input  logic              regWrite2,
    input  logic [ADDR_W-1:0] writeReg2,
    input  logic [DATA_W-1:0] writeData2,
    input  logic              issueValid,
    input  logic [ADDR_W-1:0] issueReg,
    output logic              issueErr
);

    localparam int NUM_REGS = 2**ADDR_W;

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pendingNext;
    logic                wr1En;
    logic                wr2En;
    logic                issueSet;

    // Index 0 is inert (never stored, forwarded or pending) when hardwired to zero.
    function automatic logic idxOk(input logic [ADDR_W-1:0] idx);
        return !((ZERO_REG != 0) && (idx == '0));
    endfunction

    function automatic logic [DATA_W-1:0] readData(input logic [ADDR_W-1:0] idx);
        if (!idxOk(idx))
            return '0;
        if ((BYPASS != 0) && wr1En && (writeReg == idx))
            return writeData;
        if ((BYPASS != 0) && wr2En && (writeReg2 == idx))
            return writeData2;
        return regs[idx];
    endfunction

    function automatic logic readBusy(input logic [ADDR_W-1:0] idx);
        if (!idxOk(idx))
            return 1'b0;
        if ((BYPASS != 0) && regWrite2 && (writeReg2 == idx))
            return 1'b0;
        return pending[idx];
    endfunction

    assign wr1En    = regWrite && idxOk(writeReg);
    assign wr2En    = regWrite2 && idxOk(writeReg2);
    assign issueSet = issueValid && idxOk(issueReg);

    // Set after clear so a fresh issue keeps the bit on a same-cycle retire.
    always_comb begin
        pendingNext = pending;
        if (regWrite2)
            pendingNext[writeReg2] = 1'b0;
        if (issueSet)
            pendingNext[issueReg] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
            pending  <= '0;
            issueErr <= 1'b0;
        end else begin
            if (wr2En)
                regs[writeReg2] <= writeData2;
            // Port 1 assigned last so it wins a same-index collision.
            if (wr1En)
                regs[writeReg] <= writeData;
            pending  <= pendingNext;
            issueErr <= issueSet && pending[issueReg]
                        && !(regWrite2 && (writeReg2 == issueReg));
        end
    end

    // Bypass inputs are ignored during reset, so reads are forced to zero.
    assign readDat1 = rst ? '0 : readData(readReg1);
    assign readDat2 = rst ? '0 : readData(readReg2);
    assign busy1    = rst ? 1'b0 : readBusy(readReg1);
    assign busy2    = rst ? 1'b0 : readBusy(readReg2);

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: one bypassing instance and one
// non-bypassing instance share all inputs.
module tb_regfile_scoreboard;

    logic        clk;
    logic        rst;
    logic [4:0]  readReg1, readReg2, writeReg, writeReg2, issueReg;
    logic [31:0] writeData, writeData2;
    logic        regWrite, regWrite2, issueValid;

    logic [31:0] readDat1, readDat2, nbReadDat1, nbReadDat2;
    logic        busy1, busy2, issueErr, nbBusy1, nbBusy2, nbIssueErr;

    int nVec = 0;
    int nErr = 0;

    regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut (
        .clk(clk), .rst(rst),
        .readReg1(readReg1), .readReg2(readReg2),
        .readDat1(readDat1), .readDat2(readDat2),
        .busy1(busy1), .busy2(busy2),
        .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
        .regWrite2(regWrite2), .writeReg2(writeReg2), .writeData2(writeData2),
        .issueValid(issueValid), .issueReg(issueReg), .issueErr(issueErr)
    );

    regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) dutNb (
        .clk(clk), .rst(rst),
        .readReg1(readReg1), .readReg2(readReg2),
        .readDat1(nbReadDat1), .readDat2(nbReadDat2),
        .busy1(nbBusy1), .busy2(nbBusy2),
        .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
        .regWrite2(regWrite2), .writeReg2(writeReg2), .writeData2(writeData2),
        .issueValid(issueValid), .issueReg(issueReg), .issueErr(nbIssueErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nVec++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        regWrite   = 1'b0; writeReg  = '0; writeData  = '0;
        regWrite2  = 1'b0; writeReg2 = '0; writeData2 = '0;
        issueValid = 1'b0; issueReg  = '0;
    endtask

    initial begin
        rst = 1'b1;
        readReg1 = '0;
        readReg2 = '0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        readReg1 = 5'd5;
        #1;
        chk("rst_read", {31'd0, 1'b0} | readDat1, 32'h0);
        chk("rst_busy", {31'd0, busy1}, 32'h0);
        chk("rst_err", {31'd0, issueErr}, 32'h0);
        @(negedge clk) rst = 1'b0;

        // Reset clear mid-operation
        @(negedge clk);
        regWrite = 1'b1; writeReg = 5'd5; writeData = 32'hDEADBEEF;
        issueValid = 1'b1; issueReg = 5'd7;
        readReg1 = 5'd5; readReg2 = 5'd7;
        @(posedge clk) #1 idle();
        #1;
        chk("pre_rst_read", readDat1, 32'hDEADBEEF);
        chk("pre_rst_busy", {31'd0, busy2}, 32'h1);
        chk("pre_rst_err", {31'd0, issueErr}, 32'h0);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_read", readDat1, 32'h0);
        chk("async_rst_busy", {31'd0, busy2}, 32'h0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk) #1;
        chk("post_rst_read", readDat1, 32'h0);
        chk("post_rst_busy", {31'd0, busy2}, 32'h0);

        // Zero register
        @(negedge clk);
        regWrite = 1'b1; writeReg = 5'd0; writeData = 32'h1234;
        issueValid = 1'b1; issueReg = 5'd0;
        readReg1 = 5'd0;
        #1;
        chk("zero_same_read", readDat1, 32'h0);
        chk("zero_same_busy", {31'd0, busy1}, 32'h0);
        @(posedge clk) #1 idle();
        #1;
        chk("zero_next_read", readDat1, 32'h0);
        chk("zero_next_busy", {31'd0, busy1}, 32'h0);
        chk("zero_err", {31'd0, issueErr}, 32'h0);

        // Bypass and port priority
        @(negedge clk);
        regWrite  = 1'b1; writeReg  = 5'd3; writeData  = 32'hAAAA;
        regWrite2 = 1'b1; writeReg2 = 5'd3; writeData2 = 32'h5555;
        readReg1 = 5'd3; readReg2 = 5'd3;
        #1;
        chk("byp_same_rd1", readDat1, 32'hAAAA);
        chk("byp_same_rd2", readDat2, 32'hAAAA);
        chk("nobyp_same_rd1", nbReadDat1, 32'h0);
        @(posedge clk) #1 idle();
        #1;
        chk("byp_next_rd1", readDat1, 32'hAAAA);
        chk("nobyp_next_rd1", nbReadDat1, 32'hAAAA);
        chk("nobyp_next_rd2", nbReadDat2, 32'hAAAA);

        // Scoreboard lifecycle
        @(negedge clk);
        issueValid = 1'b1; issueReg = 5'd9;
        readReg1 = 5'd9;
        #1;
        chk("issue_same_busy", {31'd0, busy1}, 32'h0);
        @(posedge clk) #1 idle();
        #1;
        chk("issue_next_busy", {31'd0, busy1}, 32'h1);
        chk("issue_next_err", {31'd0, issueErr}, 32'h0);
        @(negedge clk);
        regWrite2 = 1'b1; writeReg2 = 5'd9; writeData2 = 32'h77;
        #1;
        chk("retire_same_busy", {31'd0, busy1}, 32'h0);
        chk("retire_same_read", readDat1, 32'h77);
        chk("nobyp_retire_busy", {31'd0, nbBusy1}, 32'h1);
        chk("nobyp_retire_read", nbReadDat1, 32'h0);
        @(posedge clk) #1 idle();
        #1;
        chk("retire_next_busy", {31'd0, busy1}, 32'h0);
        chk("retire_next_read", readDat1, 32'h77);
        chk("nobyp_retnext_busy", {31'd0, nbBusy1}, 32'h0);
        chk("nobyp_retnext_read", nbReadDat1, 32'h77);

        // Simultaneous set and clear on reg 4
        @(negedge clk);
        issueValid = 1'b1; issueReg = 5'd4;
        readReg1 = 5'd4;
        @(posedge clk) #1 idle();
        @(negedge clk);
        regWrite2 = 1'b1; writeReg2 = 5'd4; writeData2 = 32'h44;
        issueValid = 1'b1; issueReg = 5'd4;
        #1;
        chk("setclr_same_busy", {31'd0, busy1}, 32'h0);
        @(posedge clk) #1 idle();
        #1;
        chk("setclr_next_busy", {31'd0, busy1}, 32'h1);
        chk("setclr_err", {31'd0, issueErr}, 32'h0);
        chk("setclr_read", readDat1, 32'h44);
        @(negedge clk);
        regWrite2 = 1'b1; writeReg2 = 5'd4; writeData2 = 32'h45;
        @(posedge clk) #1 idle();
        #1;
        chk("setclr_retired", {31'd0, busy1}, 32'h0);

        // Double issue on reg 6
        @(negedge clk);
        issueValid = 1'b1; issueReg = 5'd6;
        readReg1 = 5'd6;
        @(posedge clk) #2;
        chk("dbl_first_err", {31'd0, issueErr}, 32'h0);
        chk("dbl_first_busy", {31'd0, busy1}, 32'h1);
        @(posedge clk) #1 idle();
        #1;
        chk("dbl_second_err", {31'd0, issueErr}, 32'h1);
        chk("nobyp_dbl_err", {31'd0, nbIssueErr}, 32'h1);
        @(posedge clk) #2;
        chk("dbl_pulse_end", {31'd0, issueErr}, 32'h0);
        chk("dbl_still_busy", {31'd0, busy1}, 32'h1);
        @(negedge clk);
        regWrite2 = 1'b1; writeReg2 = 5'd6; writeData2 = 32'h66;
        @(posedge clk) #1 idle();
        #1;
        chk("dbl_retired", {31'd0, busy1}, 32'h0);
        chk("dbl_retired_err", {31'd0, issueErr}, 32'h0);
        chk("dbl_read", readDat1, 32'h66);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
